spi_slave_fifo_os: RTL and testbench

//  Next-generation SPI slave for the APB subsystem. SCK/SS/MOSI are oversampled in the PCLK domain; no logic runs on SCK.

---
 rtl/spi_slv_pkg.sv | 39 +++
 rtl/spi_slv_fifo.sv | 71 +++++++
 rtl/spi_slave_fifo_os.sv | 251 +++++++++++++++++++++++++
 tb/tb_spi_slave_fifo_os.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slv_pkg.sv
// Shared definitions for the oversampled SPI slave.
//   state_t   : FSM encoding (ST_IDLE, ST_ACTIVE)
//   INT_*     : bit positions inside the SPI_INT sticky flag vector
//   sck_edge  : picks the sample or shift edge out of the detected SCK
//               rise/fall pulses for a given CPOL/CPHA.
package spi_slv_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int INT_W   = 4;
    localparam int INT_RXF = 0;  // frame received
    localparam int INT_OVF = 1;  // rx overflow
    localparam int INT_UDR = 2;  // tx underrun
    localparam int INT_ABT = 3;  // frame abort

    // Leading edge is the rise for CPOL=0 and the fall for CPOL=1.
    // CPHA=0 samples on the leading edge and shifts on the trailing one;
    // CPHA=1 swaps the two roles.
    function automatic logic sck_edge(
        input logic rise,
        input logic fall,
        input logic cpol,
        input logic cpha,
        input logic want_sample
    );
        logic lead;
        logic trail;
        lead  = cpol ? fall : rise;
        trail = cpol ? rise : fall;
        if (want_sample) begin
            return cpha ? trail : lead;
        end
        return cpha ? lead : trail;
    endfunction

endpackage

// File: rtl/spi_slv_fifo.sv
// Synchronous first-word-fall-through FIFO used for both SPI TX and RX.
// Ports:
//   clk, rst : clock and synchronous active-high reset (empties the FIFO)
//   push     : write strobe; ignored when full unless a pop happens too
//   wdata    : word to write
//   pop      : read strobe; ignored when empty
//   rdata    : head word, forced to 0 while empty
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : current occupancy
module spi_slv_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    // A pop frees a slot in the same cycle, so push+pop while full is accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Depth is a power of two, so pointers simply wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spi_slave_fifo_os.sv
// SPI slave with TX/RX FIFOs; SCK, SS and MOSI are oversampled in PCLK so
// nothing is clocked by SCK (SCK must not exceed PCLK/8).
// Optional feature macro: SPI_SLV_LSB_FIRST_EN -- when defined, LSB_FIRST=1
// (latched at frame start) shifts LSB first in both directions. When
// undefined, LSB_FIRST is ignored and data is always MSB first.
// Ports:
//   PCLK, PRESET          : clock, synchronous active-high reset
//   SCK, SS, MOSI         : asynchronous SPI inputs from the master
//   MISO, MISO_OE         : serial output and its pad enable
//   SPI_EN                : block enable; 0 forces the FSM to IDLE
//   CPOL, CPHA, LSB_FIRST : frame format, latched at frame start
//   TX_WDATA, TX_WR       : TX FIFO push interface
//   TX_FULL, TX_LEVEL     : TX FIFO status
//   RX_RDATA, RX_RD       : RX FIFO head word and pop strobe
//   RX_EMPTY, RX_LEVEL    : RX FIFO status
//   INT_EN, INT_CLR       : interrupt enable and per-bit clear
//   SPI_INT, IRQ          : sticky flags (rxf, ovf, udr, abt) and masked OR
module spi_slave_fifo_os
    import spi_slv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FIFO_D = 4,
    parameter int LVL_W  = 3
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              SCK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic              SPI_EN,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              LSB_FIRST,
    input  logic [DATA_W-1:0] TX_WDATA,
    input  logic              TX_WR,
    output logic              TX_FULL,
    output logic [LVL_W-1:0]  TX_LEVEL,
    output logic [DATA_W-1:0] RX_RDATA,
    input  logic              RX_RD,
    output logic              RX_EMPTY,
    output logic [LVL_W-1:0]  RX_LEVEL,
    input  logic [INT_W-1:0]  INT_EN,
    input  logic [INT_W-1:0]  INT_CLR,
    output logic [INT_W-1:0]  SPI_INT,
    output logic              IRQ
);

    localparam int CNT_W = $clog2(DATA_W);

    logic              sck_p0, sck_p1, sck_p2;
    logic              ss_p0, ss_p1, ss_p2;
    logic              mosi_p0, mosi_p1;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              cpol_q, cpha_q;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic              tx_bit;

    logic              sck_rise, sck_fall, ss_fall, ss_rise;
    logic              sample_edge, shift_edge;
    logic              frame_start, in_frame, do_sample, do_shift;
    logic              last_bit, frame_done, tx_load, abort;
    logic              rx_full, tx_empty;
    logic [DATA_W-1:0] tx_rdata;
    logic [INT_W-1:0]  flag_set;

    // ---- input synchronisers: p0/p1 resolve metastability, p2 edge-detects
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sck_p0 <= 1'b0;
            sck_p1 <= 1'b0;
            sck_p2 <= 1'b0;
            ss_p0  <= 1'b1;
            ss_p1  <= 1'b1;
            ss_p2  <= 1'b1;
        end else begin
            sck_p0 <= SCK;
            sck_p1 <= sck_p0;
            sck_p2 <= sck_p1;
            ss_p0  <= SS;
            ss_p1  <= ss_p0;
            ss_p2  <= ss_p1;
        end
    end

    // MOSI carries the same two-stage latency as SCK so its setup to the
    // sample edge is preserved after synchronisation.
    always_ff @(posedge PCLK) begin
        mosi_p0 <= MOSI;
        mosi_p1 <= mosi_p0;
    end

    // ---- edge detection and frame control decode
    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign ss_fall  = ~ss_p1 & ss_p2;
    assign ss_rise  = ss_p1 & ~ss_p2;

    assign sample_edge = sck_edge(sck_rise, sck_fall, cpol_q, cpha_q, 1'b1);
    assign shift_edge  = sck_edge(sck_rise, sck_fall, cpol_q, cpha_q, 1'b0);

    assign frame_start = (state == ST_IDLE) & SPI_EN & ss_fall;
    assign in_frame    = (state == ST_ACTIVE) & SPI_EN & ~ss_rise;
    assign do_sample   = in_frame & sample_edge;
    assign last_bit    = (bit_cnt == CNT_W'(DATA_W - 1));
    assign frame_done  = do_sample & last_bit;

    // A shift edge seen before any sample of the current word is skipped:
    // with CPHA=1 that is the first leading edge of the frame, and after a
    // back-to-back reload it is the edge that would otherwise discard the
    // freshly loaded first bit.
    assign do_shift = in_frame & shift_edge & (bit_cnt != '0);

    assign tx_load = frame_start | frame_done;
    assign abort   = (state == ST_ACTIVE) & SPI_EN & ss_rise & (bit_cnt != '0);

`ifdef SPI_SLV_LSB_FIRST_EN
    logic lsb_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            lsb_q <= 1'b0;
        end else if (frame_start) begin
            lsb_q <= LSB_FIRST;
        end
    end

    // LSB-first words fill from the top so the first bit ends up at bit 0.
    assign rx_next = lsb_q ? {mosi_p1, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], mosi_p1};
    assign tx_next = lsb_q ? {1'b0, tx_sh[DATA_W-1:1]}    : {tx_sh[DATA_W-2:0], 1'b0};
    assign tx_bit  = lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
`else
    logic unused_lsb_first;

    assign unused_lsb_first = LSB_FIRST;
    assign rx_next = {rx_sh[DATA_W-2:0], mosi_p1};
    assign tx_next = {tx_sh[DATA_W-2:0], 1'b0};
    assign tx_bit  = tx_sh[DATA_W-1];
`endif

    // ---- frame FSM
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state   <= ST_ACTIVE;
                        bit_cnt <= '0;
                        cpol_q  <= CPOL;
                        cpha_q  <= CPHA;
                    end
                end
                ST_ACTIVE: begin
                    if (!SPI_EN || ss_rise) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end else if (do_sample) begin
                        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // ---- shift registers (datapath, no reset); an empty TX FIFO loads 0
    always_ff @(posedge PCLK) begin
        if (tx_load) begin
            tx_sh <= tx_empty ? '0 : tx_rdata;
        end else if (do_shift) begin
            tx_sh <= tx_next;
        end
        if (do_sample) begin
            rx_sh <= rx_next;
        end
    end

    // ---- FIFOs
    spi_slv_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_D),
        .LVL_W (LVL_W)
    ) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (TX_WR),
        .wdata (TX_WDATA),
        .pop   (tx_load),
        .rdata (tx_rdata),
        .full  (TX_FULL),
        .empty (tx_empty),
        .level (TX_LEVEL)
    );

    // The completed word goes straight from rx_next so RX_EMPTY drops one
    // PCLK after the completing sample edge is detected.
    spi_slv_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_D),
        .LVL_W (LVL_W)
    ) u_rx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (frame_done),
        .wdata (rx_next),
        .pop   (RX_RD),
        .rdata (RX_RDATA),
        .full  (rx_full),
        .empty (RX_EMPTY),
        .level (RX_LEVEL)
    );

    // ---- sticky interrupt flags; a set wins over a same-cycle clear
    always_comb begin
        flag_set          = '0;
        flag_set[INT_RXF] = frame_done;
        // A pop in the same cycle frees a slot, so the word is not lost.
        flag_set[INT_OVF] = frame_done & rx_full & ~RX_RD;
        flag_set[INT_UDR] = tx_load & tx_empty;
        flag_set[INT_ABT] = abort;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            SPI_INT <= '0;
        end else begin
            SPI_INT <= (SPI_INT & ~INT_CLR) | flag_set;
        end
    end

    assign IRQ = |(SPI_INT & INT_EN);

    // ---- pad outputs
    assign MISO_OE = SPI_EN & ~ss_p1;
    assign MISO    = (MISO_OE && state == ST_ACTIVE) ? tx_bit : 1'b0;

endmodule

// File: tb/tb_spi_slave_fifo_os.sv
module tb_spi_slave_fifo_os;

    localparam int DATA_W = 8;
    localparam int FIFO_D = 4;
    localparam int LVL_W  = 3;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              SCK, SS, MOSI;
    logic              MISO, MISO_OE;
    logic              SPI_EN, CPOL, CPHA, LSB_FIRST;
    logic [DATA_W-1:0] TX_WDATA;
    logic              TX_WR;
    logic              TX_FULL;
    logic [LVL_W-1:0]  TX_LEVEL;
    logic [DATA_W-1:0] RX_RDATA;
    logic              RX_RD;
    logic              RX_EMPTY;
    logic [LVL_W-1:0]  RX_LEVEL;
    logic [3:0]        INT_EN, INT_CLR;
    logic [3:0]        SPI_INT;
    logic              IRQ;

    spi_slave_fifo_os #(
        .DATA_W (DATA_W),
        .FIFO_D (FIFO_D),
        .LVL_W  (LVL_W)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .SCK       (SCK),
        .SS        (SS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .MISO_OE   (MISO_OE),
        .SPI_EN    (SPI_EN),
        .CPOL      (CPOL),
        .CPHA      (CPHA),
        .LSB_FIRST (LSB_FIRST),
        .TX_WDATA  (TX_WDATA),
        .TX_WR     (TX_WR),
        .TX_FULL   (TX_FULL),
        .TX_LEVEL  (TX_LEVEL),
        .RX_RDATA  (RX_RDATA),
        .RX_RD     (RX_RD),
        .RX_EMPTY  (RX_EMPTY),
        .RX_LEVEL  (RX_LEVEL),
        .INT_EN    (INT_EN),
        .INT_CLR   (INT_CLR),
        .SPI_INT   (SPI_INT),
        .IRQ       (IRQ)
    );

    always #5 PCLK = ~PCLK;

    int         total = 0;
    int         fails = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [3:0] m_flags;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge PCLK);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".miso"},     MISO, 0);
        chk({tag, ".miso_oe"},  MISO_OE, 0);
        chk({tag, ".tx_full"},  TX_FULL, 0);
        chk({tag, ".tx_level"}, TX_LEVEL, 0);
        chk({tag, ".rx_rdata"}, RX_RDATA, 0);
        chk({tag, ".rx_empty"}, RX_EMPTY, 1);
        chk({tag, ".rx_level"}, RX_LEVEL, 0);
        chk({tag, ".spi_int"},  SPI_INT, 0);
        chk({tag, ".irq"},      IRQ, 0);
    endtask

    task automatic state_checks(input string tag);
        logic [7:0] head;
        head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        chk({tag, ".rx_level"}, RX_LEVEL, rx_q.size());
        chk({tag, ".rx_empty"}, RX_EMPTY, rx_q.size() == 0);
        chk({tag, ".rx_rdata"}, RX_RDATA, head);
        chk({tag, ".tx_level"}, TX_LEVEL, tx_q.size());
        chk({tag, ".tx_full"},  TX_FULL, tx_q.size() == FIFO_D);
        chk({tag, ".spi_int"},  SPI_INT, m_flags);
        chk({tag, ".irq"},      IRQ, |(m_flags & INT_EN));
    endtask

    task automatic push_tx(input logic [7:0] w);
        TX_WDATA = w;
        TX_WR    = 1'b1;
        @(negedge PCLK);
        TX_WR    = 1'b0;
        if (tx_q.size() < FIFO_D) tx_q.push_back(w);
    endtask

    task automatic pop_rx(input string tag);
        if (rx_q.size() > 0) chk({tag, ".pop_data"}, RX_RDATA, rx_q[0]);
        RX_RD = 1'b1;
        @(negedge PCLK);
        RX_RD = 1'b0;
        if (rx_q.size() > 0) rx_q.delete(0);
    endtask

    task automatic clear_flags(input logic [3:0] f);
        INT_CLR = f;
        @(negedge PCLK);
        INT_CLR = 4'h0;
        m_flags = m_flags & ~f;
    endtask

    // SPI master: SCK half period = 4 PCLK, MSB first, bits driven/sampled per mode.
    task automatic xfer(input logic [1:0] mode, input logic [7:0] mo, input int nbits,
                        input bit clr_last, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        CPOL = cpol;
        CPHA = cpha;
        SCK  = cpol;
        mi   = 8'h00;
        half();
        SS = 1'b0;
        half();
        chk("xfer.miso_oe_on", MISO_OE, SPI_EN);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                MOSI = mo[7-i];
                half();
                mi[7-i] = MISO;
                SCK = ~cpol;
            end else begin
                SCK  = ~cpol;
                MOSI = mo[7-i];
                half();
                mi[7-i] = MISO;
                SCK = cpol;
            end
            // The DUT acts on the sample edge at the third PCLK after the toggle.
            if (clr_last && i == nbits - 1) begin
                @(negedge PCLK);
                @(negedge PCLK);
                INT_CLR = 4'b0001;
                @(negedge PCLK);
                INT_CLR = 4'b0000;
                @(negedge PCLK);
            end else begin
                half();
            end
            if (!cpha) SCK = cpol;
        end
        if (!cpha) half();
        SS = 1'b1;
        repeat (6) @(negedge PCLK);
        chk("xfer.miso_oe_off", MISO_OE, 0);
    endtask

    // Reference: each SS session loads a word at start and again after every
    // completed frame; an empty TX FIFO yields 0 and the underrun flag.
    task automatic session(input string tag, input logic [1:0] mode, input logic [7:0] mo,
                           input int nbits, input bit clr_last);
        logic [7:0] cur, mi, mask;
        cur = 8'h00;
        if (SPI_EN) begin
            if (tx_q.size() > 0) cur = tx_q.pop_front();
            else m_flags[2] = 1'b1;
            if (nbits == 8) begin
                if (rx_q.size() < FIFO_D) rx_q.push_back(mo);
                else m_flags[1] = 1'b1;
                m_flags[0] = 1'b1;
                if (tx_q.size() > 0) tx_q.delete(0);
                else m_flags[2] = 1'b1;
            end else begin
                m_flags[3] = 1'b1;
            end
        end
        xfer(mode, mo, nbits, clr_last, mi);
        mask = ~(8'hFF >> nbits);
        chk({tag, ".miso_word"}, mi & mask, cur & mask);
        state_checks(tag);
    endtask

    initial begin
        logic [1:0] md;
        int         nb;
        PRESET = 1'b1; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
        SPI_EN = 1'b0; CPOL = 1'b0; CPHA = 1'b0; LSB_FIRST = 1'b0;
        TX_WDATA = '0; TX_WR = 1'b0; RX_RD = 1'b0;
        INT_EN = 4'h0; INT_CLR = 4'h0;
        m_flags = 4'h0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        reset_checks("reset");

        SPI_EN = 1'b1;
        INT_EN = 4'b0101;

        // Mode 0 basic frame
        push_tx(8'hA5);
        session("mode0", 2'd0, 8'h3C, 8, 1'b0);
        chk("mode0.rxf", SPI_INT[0], 1);
        pop_rx("mode0");
        clear_flags(4'hF);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            push_tx(8'h5A);
            session($sformatf("mode%0d", m), m[1:0], 8'hC3, 8, 1'b0);
            pop_rx($sformatf("mode%0d", m));
            clear_flags(4'hF);
        end

        // TX empty: underrun, IRQ follows INT_EN[2]
        INT_EN = 4'b0100;
        session("udr", 2'd0, 8'h81, 8, 1'b0);
        chk("udr.irq_on", IRQ, 1);
        INT_EN = 4'b0000;
        @(negedge PCLK);
        chk("udr.irq_off", IRQ, 0);
        pop_rx("udr");
        clear_flags(4'hF);
        INT_EN = 4'b1111;

        // TX full: fifth push ignored
        for (int i = 0; i < 5; i++) push_tx(8'(8'h10 + i));
        @(negedge PCLK);
        state_checks("txfull");
        session("txfull_frame", 2'd2, 8'hE7, 8, 1'b0);
        pop_rx("txfull");
        clear_flags(4'hF);

        // RX overflow: five frames without popping
        for (int i = 0; i < 5; i++) begin
            session($sformatf("ovf%0d", i), 2'd0, 8'($urandom_range(0, 255)), 8, 1'b0);
        end
        chk("ovf.flag", SPI_INT[1], 1);
        chk("ovf.level", RX_LEVEL, 4);
        while (rx_q.size() > 0) pop_rx("ovf_drain");
        clear_flags(4'hF);

        // Abort after three bits, then a good frame
        push_tx(8'h96);
        session("abort", 2'd1, 8'($urandom_range(0, 255)), 3, 1'b0);
        chk("abort.flag", SPI_INT[3], 1);
        push_tx(8'h69);
        session("after_abort", 2'd1, 8'h7E, 8, 1'b0);
        pop_rx("after_abort");
        clear_flags(4'hF);

        // Clear of RXF coinciding with frame completion
        push_tx(8'h44);
        session("clr_race", 2'd0, 8'h11, 8, 1'b1);
        chk("clr_race.rxf", SPI_INT[0], 1);
        pop_rx("clr_race");
        clear_flags(4'hF);

        // Reset in the middle of a frame
        push_tx(8'h33);
        CPOL = 1'b0; CPHA = 1'b0; SCK = 1'b0;
        half();
        SS = 1'b0;
        half();
        for (int i = 0; i < 3; i++) begin
            MOSI = i[0];
            half();
            SCK = ~SCK;
        end
        PRESET = 1'b1;
        SS = 1'b1;
        SCK = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        tx_q.delete();
        rx_q.delete();
        m_flags = 4'h0;
        @(negedge PCLK);
        reset_checks("midreset");
        push_tx(8'hC8);
        session("post_reset", 2'd3, 8'h2D, 8, 1'b0);
        pop_rx("post_reset");
        clear_flags(4'hF);

        // Disabled block ignores a whole frame
        push_tx(8'hF0);
        SPI_EN = 1'b0;
        session("disabled", 2'd0, 8'hAB, 8, 1'b0);
        SPI_EN = 1'b1;

        // Randomised sessions
        for (int it = 0; it < 10; it++) begin
            md = 2'($urandom_range(0, 3));
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            for (int p = $urandom_range(0, 2); p > 0; p--) push_tx(8'($urandom_range(0, 255)));
            session($sformatf("rand%0d", it), md, 8'($urandom_range(0, 255)), nb, 1'b0);
            if ($urandom_range(0, 1) == 1) pop_rx($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) clear_flags(4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
